hidden_ram_arbiter: RTL and testbench
=====================================

Name: hidden_ram_arbiter

Overview:
- Sits in front of the single-port hidden-unit RAM (8-bit data, 32 entries, registered read address, 1-cycle read latency).
- Shares that RAM between the hidden-layer producer (writes unit activations) and the output-layer consumer (reads them).
- Keeps a per-entry written scoreboard so the consumer can never read a hidden unit before it is produced in the current inference.
- Reports when the whole hidden layer has been written.

Parameters:
- DATA_WIDTH, 8, width of one hidden-unit value
- ADDR_WIDTH, 5, RAM address width
- NUM_UNITS, 32, hidden units per inference; must satisfy 1 <= NUM_UNITS <= 2**ADDR_WIDTH

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  start of new inference; clears scoreboard
- wr_req  in  1  producer write request
- wr_addr  in  ADDR_WIDTH  producer address
- wr_data  in  DATA_WIDTH  producer data
- wr_gnt  out  1  write accepted this cycle
- rd_req  in  1  consumer read request
- rd_addr  in  ADDR_WIDTH  consumer address
- rd_gnt  out  1  read accepted this cycle
- rd_valid  out  1  rd_data valid (one cycle after rd_gnt)
- rd_data  out  DATA_WIDTH  read result
- ram_we  out  1  to RAM we
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_data  out  DATA_WIDTH  to RAM data
- ram_q  in  DATA_WIDTH  from RAM q
- all_written  out  1  all NUM_UNITS entries written since last clr
- addr_err  out  1  one-cycle pulse on an access with addr >= NUM_UNITS

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n).
  - Reset values: scoreboard all 0, written count 0, all_written 0, rd_valid 0, rd_data 0, addr_err 0, round-robin pointer = write-preferred.
  - The grants and ram_* outputs are combinational and are 0 while rst_n is low.
- Handshake:
  - A transfer occurs in a cycle where req && gnt.
  - Requesters hold req, addr and data stable until granted.
  - gnt is combinational from the current req and the registered state; there is no dependency from gnt back to req.
- Eligibility:
  - Write: wr_req && !clr.
  - Read: rd_req && !clr && (scoreboard[rd_addr] || rd_addr >= NUM_UNITS).
  - The scoreboard is the registered value, so a write in cycle N makes the read of that address eligible from cycle N+1.
- Arbitration, at most one grant per cycle:
  - Only one eligible requester: it wins.
  - Both eligible: the pointer decides. After a contended grant, the pointer flips to favour the loser.
  - Uncontended grants leave the pointer unchanged.
- RAM drive:
  - Write winner: ram_we=1, ram_addr=wr_addr, ram_data=wr_data.
  - Read winner: ram_we=0, ram_addr=rd_addr.
  - No winner: ram_we=0, ram_addr holds the last driven address, ram_data=0.
  - Out-of-range winner (addr >= NUM_UNITS): ram_we is forced 0. The access is still granted and addr_err pulses on the next cycle.
- Read pipeline:
  - rd_valid is registered: 1 in cycle N+1 iff rd_gnt in cycle N.
  - rd_data is registered from ram_q, or 0 for out-of-range reads. It holds its value when rd_valid=0.
  - Latency from rd_gnt to data: exactly 1 cycle. Back-to-back reads give one result per cycle.
- Scoreboard:
  - An in-range write sets its bit.
  - The written count increments only when the bit was previously 0; rewrites overwrite the data but do not change the count.
  - all_written is registered: 1 when count == NUM_UNITS.
- clr:
  - Synchronous and highest priority: no grants in that cycle.
  - Scoreboard, count and all_written go to 0 at the next edge; the pointer is unaffected.
  - A rd_valid from a grant in the previous cycle is still delivered.
- Same address, same cycle:
  - Entry not yet valid: only the write is eligible, so it wins and the read follows.
  - Entry already valid: the pointer decides. A read that wins returns the old data.
- Reset mid-operation: the in-flight rd_valid is dropped and the scoreboard is lost; producers must restart the inference.

Decomposition:
- Shared package hidden_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_UNITS
  - typedefs unit_t (logic [DATA_WIDTH-1:0]) and uaddr_t (logic [ADDR_WIDTH-1:0])
  - enum owner_e {OWN_WR, OWN_RD} for the pointer
- One natural sub-module: hidden_scoreboard, which holds the valid bits, the written count and all_written, with set/clr/lookup ports.
- The arbiter, RAM drive and read pipeline stay in hidden_ram_arbiter.

Test Plan:
- Reset, then write addr 0..31 with data 8'h10+addr and no reads -> one wr_gnt per cycle; all_written rises the cycle after the 32nd write, not before.
- rd_req addr 5 before it is written, then write 5=8'hA5 -> rd_gnt stays 0 until the cycle after wr_gnt; rd_valid=1 with rd_data=8'hA5 one cycle after rd_gnt.
- All entries written; wr_req and rd_req held continuously, both at addr 3 -> grants alternate W,R,W,R starting with W; every read returns the most recent completed write.
- Back-to-back reads of addr 0,1,2 -> rd_valid high for 3 consecutive cycles with data 8'h10, 8'h11, 8'h12.
- clr asserted while both requests are pending -> no grant that cycle; all_written=0 next cycle; a read of addr 7 then stalls until 7 is rewritten.
- NUM_UNITS=20, read addr 25 -> granted, ram_we=0, rd_data=0, addr_err pulses once; a write to addr 25 does not increment the count.

Source files
------------

// File: rtl/hidden_pkg.sv
// Shared sizing, typedefs and arbitration owner encoding
// for the hidden-unit RAM arbiter slice.
package hidden_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_UNITS  = 32;

  typedef logic [DATA_WIDTH-1:0] unit_t;
  typedef logic [ADDR_WIDTH-1:0] uaddr_t;

  typedef enum logic {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_e;

endpackage

// File: rtl/hidden_scoreboard.sv
// Per-entry written bits, count of distinct entries written,
// and the registered all-written flag for one inference.
module hidden_scoreboard #(
  parameter int ADDR_WIDTH = hidden_pkg::ADDR_WIDTH,
  parameter int NUM_UNITS  = hidden_pkg::NUM_UNITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  set,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit,
  output logic                  all_written
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = $clog2(NUM_UNITS + 1);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH + 1)'(NUM_UNITS);
  localparam logic [CW-1:0] FULL = CW'(NUM_UNITS);

  logic [DEPTH-1:0] vld_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             set_in;
  logic             first;

  assign set_in = set && ({1'b0, set_addr} < LIMIT);
  assign first  = set_in && !vld_q[set_addr];
  assign cnt_d  = clr ? '0 : cnt_q + CW'(first);

  // bits at or above NUM_UNITS are never set, so those lookups miss
  assign hit = vld_q[lookup_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      cnt_q       <= '0;
      all_written <= 1'b0;
    end else begin
      if (clr) begin
        vld_q <= '0;
      end else if (first) begin
        vld_q[set_addr] <= 1'b1;
      end
      cnt_q       <= cnt_d;
      all_written <= (cnt_d == FULL);
    end
  end

endmodule

// File: rtl/hidden_ram_arbiter.sv
// Round-robin arbiter sharing the hidden-unit RAM between
// the hidden-layer producer and the output-layer consumer.
module hidden_ram_arbiter #(
  parameter int DATA_WIDTH = hidden_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = hidden_pkg::ADDR_WIDTH,
  parameter int NUM_UNITS  = hidden_pkg::NUM_UNITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  all_written,
  output logic                  addr_err
);

  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH + 1)'(NUM_UNITS);

  hidden_pkg::owner_e ptr_q;

  logic                  hit;
  logic                  wr_in;
  logic                  rd_in;
  logic                  wr_elig;
  logic                  rd_elig;
  logic                  wr_win;
  logic                  rd_win;
  logic                  rd_oor_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] q_sel;

  hidden_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_UNITS  (NUM_UNITS)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .set         (wr_gnt),
    .set_addr    (wr_addr),
    .lookup_addr (rd_addr),
    .hit         (hit),
    .all_written (all_written)
  );

  assign wr_in   = {1'b0, wr_addr} < LIMIT;
  assign rd_in   = {1'b0, rd_addr} < LIMIT;
  assign wr_elig = wr_req && !clr;
  assign rd_elig = rd_req && !clr && (hit || !rd_in);

  assign wr_win = wr_elig &&
    (!rd_elig || ptr_q == hidden_pkg::OWN_WR);
  assign rd_win = rd_elig && !wr_win;

  assign wr_gnt = rst_n && wr_win;
  assign rd_gnt = rst_n && rd_win;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = last_addr_q;
    ram_data = '0;
    unique case (1'b1)
      wr_gnt: begin
        ram_we   = wr_in;
        ram_addr = wr_addr;
        ram_data = wr_data;
      end
      rd_gnt: ram_addr = rd_addr;
      default: ;
    endcase
  end

  // RAM output is already one cycle behind the granted address
  assign q_sel   = rd_oor_q ? '0 : ram_q;
  assign rd_data = rd_valid ? q_sel : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= hidden_pkg::OWN_WR;
      last_addr_q <= '0;
      rd_valid    <= 1'b0;
      rd_oor_q    <= 1'b0;
      hold_q      <= '0;
      addr_err    <= 1'b0;
    end else begin
      rd_valid <= rd_gnt;
      if (rd_gnt) begin
        rd_oor_q <= !rd_in;
      end
      if (rd_valid) begin
        hold_q <= q_sel;
      end
      addr_err <= (wr_gnt && !wr_in) ||
                  (rd_gnt && !rd_in);
      if (wr_gnt || rd_gnt) begin
        last_addr_q <= ram_addr;
      end
      if (wr_elig && rd_elig) begin
        if (wr_win) begin
          ptr_q <= hidden_pkg::OWN_RD;
        end else begin
          ptr_q <= hidden_pkg::OWN_WR;
        end
      end
    end
  end

endmodule

// File: tb/tb_hidden_ram_arbiter.sv
// Bench for hidden_ram_arbiter: directed scenarios plus random
// traffic against a behavioural model; second instance with 20 units.
module tb_hidden_ram_arbiter;

  localparam int NU = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic       clr, wr_req, rd_req;
  logic [4:0] wr_addr, rd_addr, ram_addr;
  logic [7:0] wr_data, rd_data, ram_data, ram_q;
  logic       wr_gnt, rd_gnt, rd_valid, ram_we;
  logic       all_written, addr_err;

  logic       clr_b, wr_req_b, rd_req_b;
  logic [4:0] wr_addr_b, rd_addr_b, ram_addr_b;
  logic [7:0] wr_data_b, rd_data_b, ram_data_b, ram_q_b;
  logic       wr_gnt_b, rd_gnt_b, rd_valid_b, ram_we_b;
  logic       all_written_b, addr_err_b;

  hidden_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_q(ram_q), .all_written(all_written), .addr_err(addr_err)
  );

  hidden_ram_arbiter #(.NUM_UNITS(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .clr(clr_b),
    .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_gnt(wr_gnt_b), .rd_req(rd_req_b), .rd_addr(rd_addr_b),
    .rd_gnt(rd_gnt_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b),
    .ram_data(ram_data_b), .ram_q(ram_q_b),
    .all_written(all_written_b), .addr_err(addr_err_b)
  );

  // single-port RAMs: registered address, one-cycle read latency
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  always @(posedge clk) begin
    if (ram_we) mem_a[ram_addr] <= ram_data;
    ram_q <= mem_a[ram_addr];
    if (ram_we_b) mem_b[ram_addr_b] <= ram_data_b;
    ram_q_b <= mem_b[ram_addr_b];
  end

  int ntests = 0;
  int nfail  = 0;

  // behavioural model of the 32-unit instance
  bit         m_sb [NU];
  int         m_cnt;
  bit         m_all, m_pref_wr, m_rv, m_ew, m_er;
  logic [7:0] m_mem [NU];
  logic [7:0] m_rd;
  logic [4:0] m_last;
  bit         pw, pr;

  task automatic model_reset();
    foreach (m_sb[i]) m_sb[i] = 0;
    m_cnt = 0; m_all = 0; m_pref_wr = 1;
    m_rv = 0; m_rd = 8'h00; m_last = 5'd0;
  endtask

  task automatic predict();
    m_ew = wr_req && !clr;
    m_er = rd_req && !clr && m_sb[rd_addr];
    if (m_ew && m_er) begin
      pw = m_pref_wr; pr = !m_pref_wr;
    end else begin
      pw = m_ew; pr = m_er;
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    m_rv = pr;
    if (pr) m_rd = m_mem[rd_addr];
    if (pw) begin
      m_mem[wr_addr] = wr_data;
      if (!m_sb[wr_addr]) begin
        m_sb[wr_addr] = 1; m_cnt++;
      end
      m_last = wr_addr;
    end else if (pr) begin
      m_last = rd_addr;
    end
    if (m_ew && m_er) m_pref_wr = !pw;
    if (clr) begin
      foreach (m_sb[i]) m_sb[i] = 0;
      m_cnt = 0;
    end
    m_all = (m_cnt == NU);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; clr = 0; wr_req = 1; rd_req = 1;
    wr_addr = 5'd1; rd_addr = 5'd2; wr_data = 8'h55;
    clr_b = 0; wr_req_b = 0; rd_req_b = 0;
    wr_addr_b = 0; rd_addr_b = 0; wr_data_b = 0;
    #12;
    ntests++;
    if ({wr_gnt, rd_gnt, ram_we, rd_valid,
         all_written, addr_err} !== 6'b0 ||
        rd_data !== 8'h00 || ram_data !== 8'h00) begin
      nfail++;
      $display("FAIL reset: gnt=%b%b we=%b rv=%b aw=%b err=%b rd=%h, want all 0",
               wr_gnt, rd_gnt, ram_we, rd_valid,
               all_written, addr_err, rd_data);
    end
    wr_req = 0; rd_req = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int a = 0; a < NU; a++) begin
      wr_req = 1; wr_addr = 5'(a); wr_data = 8'(8'h10 + a);
      @(negedge clk);
      ntests++;
      if (wr_gnt !== 1'b1 || ram_we !== 1'b1 ||
          ram_addr !== 5'(a) || ram_data !== 8'(8'h10 + a)) begin
        nfail++;
        $display("FAIL fill[%0d]: gnt=%b we=%b addr=%0d data=%h, want 1 1 %0d %h",
                 a, wr_gnt, ram_we, ram_addr, ram_data,
                 a, 8'(8'h10 + a));
      end
      ntests++;
      if (all_written !== 1'b0) begin
        nfail++;
        $display("FAIL fill_early_aw[%0d]: got %b want 0",
                 a, all_written);
      end
      tick();
    end
    wr_req = 0;
    @(negedge clk);
    ntests++;
    if (all_written !== 1'b1) begin
      nfail++;
      $display("FAIL fill_aw: got %b want 1", all_written);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      rd_req = 1; rd_addr = 5'(k);
      @(negedge clk);
      ntests++;
      if (rd_gnt !== 1'b1) begin
        nfail++;
        $display("FAIL b2b_gnt[%0d]: got %b want 1", k, rd_gnt);
      end
      if (k > 0) begin
        ntests++;
        if (rd_valid !== 1'b1 ||
            rd_data !== 8'(8'h10 + k - 1)) begin
          nfail++;
          $display("FAIL b2b_data[%0d]: rv=%b d=%h want 1 %h",
                   k, rd_valid, rd_data, 8'(8'h10 + k - 1));
        end
      end
      tick();
    end
    rd_req = 0;
    @(negedge clk);
    ntests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h12) begin
      nfail++;
      $display("FAIL b2b_last: rv=%b d=%h want 1 12",
               rd_valid, rd_data);
    end
    tick();
    @(negedge clk);
    ntests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h12) begin
      nfail++;
      $display("FAIL b2b_hold: rv=%b d=%h want 0 12",
               rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [7:0] cur, pend;
    bit         pend_v;
    cur = 8'h13; pend = 8'h00; pend_v = 0;
    wr_req = 1; wr_addr = 5'd3; wr_data = 8'($urandom);
    rd_req = 1; rd_addr = 5'd3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pend_v) begin
        ntests++;
        if (rd_valid !== 1'b1 || rd_data !== pend) begin
          nfail++;
          $display("FAIL cont_data[%0d]: rv=%b d=%h want 1 %h",
                   i, rd_valid, rd_data, pend);
        end
      end
      ntests++;
      if (wr_gnt !== (i % 2 == 0) || rd_gnt !== (i % 2 == 1)) begin
        nfail++;
        $display("FAIL cont_gnt[%0d]: w=%b r=%b want w=%b",
                 i, wr_gnt, rd_gnt, (i % 2 == 0));
      end
      tick();
      pend_v = 0;
      if (i % 2 == 0) begin
        cur = wr_data; wr_data = 8'($urandom);
      end else begin
        pend = cur; pend_v = 1;
      end
    end
    wr_req = 0; rd_req = 0;
    @(negedge clk);
    ntests++;
    if (rd_valid !== 1'b1 || rd_data !== pend) begin
      nfail++;
      $display("FAIL cont_last: rv=%b d=%h want 1 %h",
               rd_valid, rd_data, pend);
    end
    tick();
  endtask

  task automatic test_clr();
    rd_req = 1; rd_addr = 5'd3;
    @(negedge clk);
    ntests++;
    if (rd_gnt !== 1'b1) begin
      nfail++;
      $display("FAIL clr_pre: rd_gnt=%b want 1", rd_gnt);
    end
    tick();
    clr = 1; wr_req = 1; wr_addr = 5'd9; wr_data = 8'h99;
    rd_addr = 5'd7;
    @(negedge clk);
    ntests++;
    if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0 ||
        rd_valid !== 1'b1 || all_written !== 1'b1) begin
      nfail++;
      $display("FAIL clr_cycle: w=%b r=%b rv=%b aw=%b want 0 0 1 1",
               wr_gnt, rd_gnt, rd_valid, all_written);
    end
    tick();
    clr = 0; wr_req = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      ntests++;
      if (rd_gnt !== 1'b0 || all_written !== 1'b0) begin
        nfail++;
        $display("FAIL clr_stall[%0d]: r=%b aw=%b want 0 0",
                 j, rd_gnt, all_written);
      end
      tick();
    end
    wr_req = 1; wr_addr = 5'd7; wr_data = 8'h77;
    @(negedge clk);
    ntests++;
    if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0) begin
      nfail++;
      $display("FAIL clr_rewrite: w=%b r=%b want 1 0",
               wr_gnt, rd_gnt);
    end
    tick();
    wr_req = 0;
    @(negedge clk);
    ntests++;
    if (rd_gnt !== 1'b1) begin
      nfail++;
      $display("FAIL clr_release: r=%b want 1", rd_gnt);
    end
    tick();
    rd_req = 0;
    @(negedge clk);
    ntests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin
      nfail++;
      $display("FAIL clr_data: rv=%b d=%h want 1 77",
               rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_stall();
    rd_req = 1; rd_addr = 5'd5;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      ntests++;
      if (rd_gnt !== 1'b0) begin
        nfail++;
        $display("FAIL stall[%0d]: r=%b want 0", j, rd_gnt);
      end
      tick();
    end
    wr_req = 1; wr_addr = 5'd5; wr_data = 8'hA5;
    @(negedge clk);
    ntests++;
    if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0) begin
      nfail++;
      $display("FAIL stall_wr: w=%b r=%b want 1 0",
               wr_gnt, rd_gnt);
    end
    tick();
    wr_req = 0;
    @(negedge clk);
    ntests++;
    if (rd_gnt !== 1'b1) begin
      nfail++;
      $display("FAIL stall_gnt: r=%b want 1", rd_gnt);
    end
    tick();
    rd_req = 0;
    @(negedge clk);
    ntests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      nfail++;
      $display("FAIL stall_data: rv=%b d=%h want 1 a5",
               rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] ea;
    logic [7:0] ed;
    int         s;
    wr_req = 0; rd_req = 0; clr = 0;
    for (int i = 0; i < 400; i++) begin
      if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1;
        wr_addr = 5'($urandom_range(0, 31));
        wr_data = 8'($urandom);
      end
      if (!rd_req && $urandom_range(0, 1) == 0) begin
        rd_req = 1;
        rd_addr = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) != 0) begin
          s = $urandom_range(0, 31);
          for (int k = 0; k < NU; k++)
            if (m_sb[(s + k) % NU]) rd_addr = 5'((s + k) % NU);
        end
      end
      clr = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      predict();
      ea = pw ? wr_addr : (pr ? rd_addr : m_last);
      ed = pw ? wr_data : 8'h00;
      ntests++;
      if (wr_gnt !== pw || rd_gnt !== pr || ram_we !== pw ||
          ram_addr !== ea || ram_data !== ed ||
          rd_valid !== m_rv || rd_data !== m_rd ||
          all_written !== m_all || addr_err !== 1'b0) begin
        nfail++;
        $display("FAIL rand[%0d]: w=%b r=%b we=%b a=%0d d=%h rv=%b rd=%h aw=%b err=%b want w=%b r=%b a=%0d d=%h rv=%b rd=%h aw=%b err=0",
                 i, wr_gnt, rd_gnt, ram_we, ram_addr, ram_data,
                 rd_valid, rd_data, all_written, addr_err,
                 pw, pr, ea, ed, m_rv, m_rd, m_all);
      end
      tick();
      if (pw) wr_req = 0;
      if (pr) rd_req = 0;
    end
    wr_req = 0; rd_req = 0; clr = 0;
  endtask

  task automatic test_oor20();
    rd_req_b = 1; rd_addr_b = 5'd25;
    @(negedge clk);
    ntests++;
    if (rd_gnt_b !== 1'b1 || ram_we_b !== 1'b0 ||
        ram_addr_b !== 5'd25 || addr_err_b !== 1'b0) begin
      nfail++;
      $display("FAIL oor_rd: r=%b we=%b a=%0d err=%b want 1 0 25 0",
               rd_gnt_b, ram_we_b, ram_addr_b, addr_err_b);
    end
    @(posedge clk); #1;
    rd_req_b = 0;
    @(negedge clk);
    ntests++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 8'h00 ||
        addr_err_b !== 1'b1) begin
      nfail++;
      $display("FAIL oor_data: rv=%b d=%h err=%b want 1 00 1",
               rd_valid_b, rd_data_b, addr_err_b);
    end
    @(posedge clk); #1;
    @(negedge clk);
    ntests++;
    if (addr_err_b !== 1'b0) begin
      nfail++;
      $display("FAIL oor_pulse: err=%b want 0", addr_err_b);
    end
    wr_req_b = 1; wr_addr_b = 5'd25; wr_data_b = 8'hEE;
    @(negedge clk);
    ntests++;
    if (wr_gnt_b !== 1'b1 || ram_we_b !== 1'b0) begin
      nfail++;
      $display("FAIL oor_wr: w=%b we=%b want 1 0",
               wr_gnt_b, ram_we_b);
    end
    @(posedge clk); #1;
    for (int a = 0; a < 20; a++) begin
      wr_addr_b = 5'(a); wr_data_b = 8'(a);
      @(negedge clk);
      if (a == 0) begin
        ntests++;
        if (addr_err_b !== 1'b1) begin
          nfail++;
          $display("FAIL oor_wr_err: err=%b want 1", addr_err_b);
        end
      end
      ntests++;
      if (all_written_b !== 1'b0) begin
        nfail++;
        $display("FAIL oor_count[%0d]: aw=%b want 0",
                 a, all_written_b);
      end
      @(posedge clk); #1;
    end
    wr_req_b = 0;
    @(negedge clk);
    ntests++;
    if (all_written_b !== 1'b1) begin
      nfail++;
      $display("FAIL oor_full: aw=%b want 1", all_written_b);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_contention();
    test_clr();
    test_stall();
    test_random();
    test_oor20();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
